// File: rtl/parking_pkg.sv
// Shared types and constants for the parking entry scheduler.
package parking_pkg;

    localparam int NUM_SLOTS = 16;
    localparam int SLOT_W    = 4;   // index width for NUM_SLOTS slots
    localparam int CNT_W     = 5;   // popcount width, must hold NUM_SLOTS itself

    // Button symbol encoding used by the entry code.
    localparam logic [1:0] SYM_L = 2'd0;
    localparam logic [1:0] SYM_R = 2'd1;
    localparam logic [1:0] SYM_U = 2'd2;
    localparam logic [1:0] SYM_D = 2'd3;

    typedef enum logic [2:0] {
        S_IDLE,
        S_GOT1,
        S_GOT2,
        S_GOT3,
        S_ALLOC,
        S_GATE,
        S_WAIT_PARK,
        S_ERR
    } state_t;

endpackage

// File: rtl/parking_free_slot_finder.sv
// Combinational lowest-free-slot search and free-slot popcount.
module parking_free_slot_finder
    import parking_pkg::*;
(
    input  logic [NUM_SLOTS-1:0] i_free,
    output logic [SLOT_W-1:0]    o_first_idx,
    output logic                 o_any_free,
    output logic [CNT_W-1:0]     o_count
);

    // Priority search from the top down so the lowest set bit wins; popcount alongside.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        o_first_idx = '0;
        o_count     = '0;
        for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
            if (i_free[i]) o_first_idx = SLOT_W'(i);
        end
        for (int i = 0; i < NUM_SLOTS; i++) begin
            o_count = o_count + CNT_W'(i_free[i]);
        end
    end

    assign o_any_free = |i_free;

endmodule

// File: rtl/parking_entry_scheduler.sv
// Entry-code FSM that reserves the lowest free slot, drives the gate and
// releases the reservation when the car parks or the park window expires.
module parking_entry_scheduler
    import parking_pkg::*;
#(
    parameter logic [5:0] ENTRY_CODE    = 6'b10_01_00,
    parameter int         ENTRY_TIMEOUT = 500,
    parameter int         GATE_CYCLES   = 100,
    parameter int         PARK_CYCLES   = 1000,
    parameter int         ERR_CYCLES    = 50,
    parameter int         TMR_W         = 24
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 btn_l,
    input  logic                 btn_r,
    input  logic                 btn_u,
    input  logic                 btn_d,
    input  logic                 btn_c,
    input  logic [NUM_SLOTS-1:0] sensor,
    output logic [NUM_SLOTS-1:0] slot_led,
    output logic                 gate_open,
    output logic [SLOT_W-1:0]    assigned_slot,
    output logic                 assigned_valid,
    output logic [CNT_W-1:0]     free_count,
    output logic                 lot_full,
    output logic                 err
);

    // Timer reload values: a state lasts (load + 1) cycles before its timeout fires.
    localparam logic [TMR_W-1:0] LD_ENTRY = TMR_W'(ENTRY_TIMEOUT - 1);
    localparam logic [TMR_W-1:0] LD_GATE  = TMR_W'(GATE_CYCLES - 1);
    localparam logic [TMR_W-1:0] LD_PARK  = TMR_W'(PARK_CYCLES - 1);
    localparam logic [TMR_W-1:0] LD_ERR   = TMR_W'(ERR_CYCLES - 1);

    state_t                r_state;
    logic [TMR_W-1:0]      r_timer;
    logic [NUM_SLOTS-1:0]  r_reserved;
    logic [4:0]            r_btn_q;     // {c, d, u, r, l}
    logic [NUM_SLOTS-1:0]  r_slot_led;
    logic [CNT_W-1:0]      r_free_count;
    logic                  r_lot_full;
    logic [SLOT_W-1:0]     r_assigned_slot;
    logic                  r_assigned_valid;
    logic                  r_gate_open;
    logic                  r_err;

    logic [4:0]            w_pulse;
    logic [2:0]            w_pulse_cnt;
    logic                  w_any_pulse;
    logic                  w_lone_c;
    logic                  w_lone_dir;
    logic [1:0]            w_sym;
    logic                  w_timer_zero;
    logic [NUM_SLOTS-1:0]  w_free_mask;
    logic [SLOT_W-1:0]     w_first_idx;
    logic                  w_any_free;
    logic [CNT_W-1:0]      w_free_cnt;

    // NOTE: during reset the reservation is already being dropped, so it is masked
    // out here to make free_count reflect the bare sensor on the first cycle after reset.
    assign w_free_mask  = ~(sensor | (rst ? '0 : r_reserved));
    assign w_timer_zero = (r_timer == '0);

    parking_free_slot_finder u_finder (
        .i_free      (w_free_mask),
        .o_first_idx (w_first_idx),
        .o_any_free  (w_any_free),
        .o_count     (w_free_cnt)
    );

    // Rising-edge pulses, pulse count and the symbol of a single direction pulse.
    always_comb begin
        w_pulse     = {btn_c, btn_d, btn_u, btn_r, btn_l} & ~r_btn_q;
        w_pulse_cnt = 3'(w_pulse[0]) + 3'(w_pulse[1]) + 3'(w_pulse[2])
                    + 3'(w_pulse[3]) + 3'(w_pulse[4]);
        w_any_pulse = (w_pulse_cnt != 3'd0);
        w_lone_c    = (w_pulse_cnt == 3'd1) && w_pulse[4];
        w_lone_dir  = (w_pulse_cnt == 3'd1) && !w_pulse[4];
        w_sym       = SYM_D;
        if (w_pulse[0])      w_sym = SYM_L;
        else if (w_pulse[1]) w_sym = SYM_R;
        else if (w_pulse[2]) w_sym = SYM_U;
    end

    // Button history; loaded even during reset so a held button yields no pulse afterwards.
    always_ff @(posedge clk) begin
        // NOTE: clocked state uses non-blocking assignments so all registers update together.
        r_btn_q <= {btn_c, btn_d, btn_u, btn_r, btn_l};
    end

    // Display registers: one cycle behind sensor and the reservation mask.
    always_ff @(posedge clk) begin
        r_free_count <= w_free_cnt;
        r_lot_full   <= (w_free_cnt == '0);
        if (rst) r_slot_led <= '0;
        else     r_slot_led <= sensor | r_reserved;
    end

    // Entry FSM with a shared saturating down-counter and registered grant outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state          <= S_IDLE;
            r_timer          <= '0;
            r_reserved       <= '0;
            r_assigned_slot  <= '0;
            r_assigned_valid <= 1'b0;
            r_gate_open      <= 1'b0;
            r_err            <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_any_pulse && !w_lone_c) begin
                        if (w_lone_dir && w_sym == ENTRY_CODE[1:0]) begin
                            r_state <= S_GOT1;
                            r_timer <= LD_ENTRY;
                        end else begin
                            r_state <= S_ERR;
                            r_timer <= LD_ERR;
                            r_err   <= 1'b1;
                        end
                    end
                end
                S_GOT1, S_GOT2: begin
                    if (w_any_pulse) begin
                        if (w_lone_dir && w_sym == ((r_state == S_GOT1) ? ENTRY_CODE[3:2]
                                                                        : ENTRY_CODE[5:4])) begin
                            r_state <= (r_state == S_GOT1) ? S_GOT2 : S_GOT3;
                            r_timer <= LD_ENTRY;
                        end else begin
                            r_state <= S_ERR;
                            r_timer <= LD_ERR;
                            r_err   <= 1'b1;
                        end
                    end else if (w_timer_zero) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_timer <= r_timer - TMR_W'(1);
                    end
                end
                S_GOT3: begin
                    if (w_lone_c) begin
                        r_state <= S_ALLOC;
                        r_timer <= '0;
                    end else if (w_any_pulse) begin
                        r_state <= S_ERR;
                        r_timer <= LD_ERR;
                        r_err   <= 1'b1;
                    end else if (w_timer_zero) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_timer <= r_timer - TMR_W'(1);
                    end
                end
                S_ALLOC: begin
                    if (w_any_free) begin
                        r_reserved[w_first_idx] <= 1'b1;
                        r_assigned_slot         <= w_first_idx;
                        r_assigned_valid        <= 1'b1;
                        r_gate_open             <= 1'b1;
                        r_state                 <= S_GATE;
                        r_timer                 <= LD_GATE;
                    end else begin
                        r_state <= S_ERR;
                        r_timer <= LD_ERR;
                        r_err   <= 1'b1;
                    end
                end
                S_GATE: begin
                    if (w_timer_zero) begin
                        r_gate_open <= 1'b0;
                        r_state     <= S_WAIT_PARK;
                        r_timer     <= LD_PARK;
                    end else begin
                        r_timer <= r_timer - TMR_W'(1);
                    end
                end
                S_WAIT_PARK: begin
                    if (sensor[r_assigned_slot] || w_timer_zero) begin
                        r_reserved       <= '0;
                        r_assigned_valid <= 1'b0;
                        r_state          <= S_IDLE;
                        r_timer          <= '0;
                    end else begin
                        r_timer <= r_timer - TMR_W'(1);
                    end
                end
                S_ERR: begin
                    if (w_timer_zero) begin
                        r_err   <= 1'b0;
                        r_state <= S_IDLE;
                    end else begin
                        r_timer <= r_timer - TMR_W'(1);
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_timer <= '0;
                end
            endcase
        end
    end

    assign slot_led       = r_slot_led;
    assign gate_open      = r_gate_open;
    assign assigned_slot  = r_assigned_slot;
    assign assigned_valid = r_assigned_valid;
    assign free_count     = r_free_count;
    assign lot_full       = r_lot_full;
    assign err            = r_err;

endmodule

// File: tb/tb_parking_entry_scheduler.sv
// Directed bench for parking_entry_scheduler with hand-computed expectations.
module tb_parking_entry_scheduler;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        btn_l = 1'b0, btn_r = 1'b0, btn_u = 1'b0, btn_d = 1'b0, btn_c = 1'b0;
    logic [15:0] sensor = 16'h0000;
    logic [15:0] slot_led;
    logic        gate_open;
    logic [3:0]  assigned_slot;
    logic        assigned_valid;
    logic [4:0]  free_count;
    logic        lot_full;
    logic        err;

    int n_checks = 0;
    int n_pass   = 0;
    int n_hi, g_seen, e_seen;

    always #5 clk = ~clk;

    parking_entry_scheduler dut (
        .clk            (clk),
        .rst            (rst),
        .btn_l          (btn_l),
        .btn_r          (btn_r),
        .btn_u          (btn_u),
        .btn_d          (btn_d),
        .btn_c          (btn_c),
        .sensor         (sensor),
        .slot_led       (slot_led),
        .gate_open      (gate_open),
        .assigned_slot  (assigned_slot),
        .assigned_valid (assigned_valid),
        .free_count     (free_count),
        .lot_full       (lot_full),
        .err            (err)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Press and release one button: 0=L 1=R 2=U 3=D 4=C.
    task automatic press(input int b);
        case (b)
            0: btn_l = 1'b1;
            1: btn_r = 1'b1;
            2: btn_u = 1'b1;
            3: btn_d = 1'b1;
            default: btn_c = 1'b1;
        endcase
        tick();
        {btn_l, btn_r, btn_u, btn_d, btn_c} = '0;
        tick();
    endtask

    // L, R, U, then C; returns right after the edge that moves the FSM into ALLOC.
    task automatic enter_code();
        press(0);
        press(1);
        press(2);
        btn_c = 1'b1;
        tick();
        btn_c = 1'b0;
    endtask

    // Count consecutive high cycles of gate_open (0), err (1) or assigned_valid (2).
    task automatic count_high(input int sel, output int n, output int gs, output int es);
        logic v;
        n  = 0;
        gs = 0;
        es = 0;
        for (int i = 0; i < 1500; i++) begin
            tick();
            {btn_l, btn_r, btn_u, btn_d, btn_c} = '0;
            if (gate_open) gs = 1;
            if (err) es = 1;
            v = (sel == 0) ? gate_open : (sel == 1) ? err : assigned_valid;
            if (v) n++;
            else if (n > 0) break;
        end
    endtask

    initial begin
        // 1: reset state, then a grant of slot 0 on an empty lot.
        sensor = 16'h0000;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst_gate", gate_open, 0);
        check("rst_err", err, 0);
        check("rst_valid", assigned_valid, 0);
        check("rst_led", slot_led, 16'h0000);
        check("rst_free", free_count, 16);
        check("rst_full", lot_full, 0);
        enter_code();
        count_high(0, n_hi, g_seen, e_seen);
        check("t1_gate_len", n_hi, 100);
        check("t1_slot", assigned_slot, 0);
        check("t1_valid", assigned_valid, 1);
        check("t1_led", slot_led, 16'h0001);
        check("t1_free", free_count, 15);
        sensor = 16'h0001;
        tick();
        check("t1_valid_drop", assigned_valid, 0);

        // 2: lower byte occupied, car parks in slot 8 during WAIT_PARK.
        sensor = 16'h00FF;
        tick();
        enter_code();
        count_high(0, n_hi, g_seen, e_seen);
        check("t2_gate_len", n_hi, 100);
        check("t2_slot", assigned_slot, 8);
        sensor = 16'h01FF;
        tick();
        check("t2_valid_drop", assigned_valid, 0);
        check("t2_slot_hold", assigned_slot, 8);
        tick();
        check("t2_led", slot_led, 16'h01FF);
        check("t2_free", free_count, 7);

        // 3: wrong second symbol, then the right code grants slot 0.
        sensor = 16'h0000;
        tick();
        tick();
        press(0);
        btn_u = 1'b1;
        count_high(1, n_hi, g_seen, e_seen);
        check("t3_err_len", n_hi, 50);
        check("t3_no_gate", g_seen, 0);
        check("t3_led", slot_led, 16'h0000);
        check("t3_free", free_count, 16);
        enter_code();
        count_high(0, n_hi, g_seen, e_seen);
        check("t3_gate_len", n_hi, 100);
        check("t3_slot", assigned_slot, 0);
        sensor = 16'h0001;
        tick();
        sensor = 16'h0000;
        tick();
        tick();

        // 4: full lot.
        sensor = 16'hFFFF;
        tick();
        tick();
        check("t4_full", lot_full, 1);
        check("t4_free", free_count, 0);
        enter_code();
        count_high(1, n_hi, g_seen, e_seen);
        check("t4_err_len", n_hi, 50);
        check("t4_no_gate", g_seen, 0);
        check("t4_led", slot_led, 16'hFFFF);

        // 5a: reservation released after the full park window.
        sensor = 16'h0000;
        tick();
        tick();
        enter_code();
        count_high(0, n_hi, g_seen, e_seen);
        check("t5_gate_len", n_hi, 100);
        check("t5_valid", assigned_valid, 1);
        count_high(2, n_hi, g_seen, e_seen);
        check("t5_park_len", n_hi, 999);
        tick();
        check("t5_led", slot_led, 16'h0000);
        check("t5_free", free_count, 16);

        // 5b: entry timeout returns silently to IDLE (an R then errors from IDLE).
        press(0);
        e_seen = 0;
        repeat (600) begin
            tick();
            if (err) e_seen = 1;
        end
        check("t5_timeout_err", e_seen, 0);
        press(1);
        check("t5_idle_after_to", err, 1);
        repeat (60) tick();
        check("t5_err_clear", err, 0);

        // 6a: simultaneous L and R in IDLE.
        btn_l = 1'b1;
        btn_r = 1'b1;
        tick();
        check("t6_multi_err", err, 1);
        {btn_l, btn_r} = '0;
        repeat (60) tick();
        check("t6_multi_clear", err, 0);

        // 6b: reset in the middle of GATE with buttons held through it.
        sensor = 16'h0000;
        enter_code();
        repeat (10) tick();
        check("t6_gate_mid", gate_open, 1);
        btn_c = 1'b1;
        btn_l = 1'b1;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t6_rst_gate", gate_open, 0);
        check("t6_rst_led", slot_led, 16'h0000);
        check("t6_rst_valid", assigned_valid, 0);
        tick();
        check("t6_post_led", slot_led, 16'h0000);
        check("t6_post_free", free_count, 16);
        check("t6_no_pulse", err, 0);
        btn_c = 1'b0;
        btn_l = 1'b0;
        tick();
        press(1);
        check("t6_idle_after_rst", err, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
